tl_rom_resp_checker: RTL

//  Passive TileLink-UL response checker for ROM/stub bring-up. Monitors A and D handshakes and

---
 rtl/tl_rom_resp_checker.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/tl_rom_resp_checker.sv
// Passive TileLink-UL response checker: compares D-channel beats against a programmable image.
// Optional simulation reporting (assertion, $error, auto-$finish) via TL_ROM_CHECK_SVA_EN.
module tl_rom_resp_checker #(
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       ADDR_W     = 64,
  parameter int unsigned       DEPTH      = 8,
  parameter int unsigned       OUTST      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h1000,
  parameter int unsigned       MODE       = 0,
  parameter int unsigned       TIMEOUT    = 1024,
  parameter int unsigned       NUM_CHECKS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     exp_we,
  input  logic [$clog2(DEPTH)-1:0] exp_idx,
  input  logic [DATA_W-1:0]        exp_wdata,
  input  logic                     a_valid,
  input  logic                     a_ready,
  input  logic [ADDR_W-1:0]        a_address,
  input  logic                     d_valid,
  input  logic                     d_ready,
  input  logic [DATA_W-1:0]        d_data,
  output logic                     mismatch,
  output logic [15:0]              pass_cnt,
  output logic [15:0]              err_cnt,
  output logic                     ovf,
  output logic                     unexp,
  output logic                     timeout,
  output logic                     chk_done
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned SHIFT = $clog2(DATA_W / 8);
  localparam int unsigned PTR_W = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam int unsigned OCC_W = $clog2(OUTST) + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic             oob;
    logic [IDX_W-1:0] idx;
  } entry_t;

  logic [DATA_W-1:0] img_q [DEPTH];
  entry_t            trk_q [OUTST];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [IDX_W-1:0] seq_q, seq_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [15:0]      pass_q, pass_d, err_q, err_d;
  logic             mism_q, mism_d;
  logic             ovf_q, ovf_d, unexp_q, unexp_d;
  logic             timeout_q, timeout_d, done_q, done_d;

  logic             a_hs, d_hs, full, empty, push, pop;
  logic [ADDR_W-1:0] a_off;
  logic             a_oob;
  logic [IDX_W-1:0] a_idx;
  entry_t           rd_e;
  logic [IDX_W-1:0] cmp_idx;
  logic             cmp_fail;

  assign a_off = a_address - BASE_ADDR;
  assign a_oob = (a_address < BASE_ADDR) || ((a_off >> SHIFT) >= ADDR_W'(DEPTH));
  assign a_idx = a_off[SHIFT +: IDX_W];
  assign rd_e  = trk_q[rd_ptr_q];

  // Image and tracker storage carry no reset; validity comes from occ_q.
  always_ff @(posedge clk) begin
    if (exp_we) img_q[exp_idx] <= exp_wdata;
    if (push)   trk_q[wr_ptr_q] <= '{oob: a_oob, idx: a_idx};
  end

  always_comb begin
    a_hs  = a_valid & a_ready;
    d_hs  = d_valid & d_ready;
    full  = (occ_q == OCC_W'(OUTST));
    empty = (occ_q == '0);
    pop   = d_hs & ~empty;
    push  = (MODE == 1) & a_hs & (~full | pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(OUTST - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(OUTST - 1)) ? '0 : rd_ptr_q + PTR_W'(1);

    // Sequential mode only counts A-minus-D, clamped to [0, OUTST].
    occ_d = occ_q;
    if (MODE == 1) begin
      occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end else if (a_hs && !d_hs && !full) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (d_hs && !a_hs && !empty) begin
      occ_d = occ_q - OCC_W'(1);
    end

    seq_d = d_hs ? seq_q + IDX_W'(1) : seq_q;

    cmp_idx  = (MODE == 1) ? rd_e.idx : seq_q;
    cmp_fail = ((MODE == 1) & (empty | rd_e.oob)) | (d_data != img_q[cmp_idx]);

    mism_d = 1'b0;
    pass_d = pass_q;
    err_d  = err_q;
    if (d_hs) begin
      mism_d = cmp_fail;
      if (cmp_fail) begin
        if (err_q != '1) err_d = err_q + 16'd1;
      end else if (pass_q != '1) begin
        pass_d = pass_q + 16'd1;
      end
    end
    done_d = done_q | (({1'b0, pass_d} + {1'b0, err_d}) >= 17'(NUM_CHECKS));

    ovf_d   = ovf_q   | ((MODE == 1) & a_hs & full & ~pop);
    unexp_d = unexp_q | ((MODE == 1) & d_hs & empty);

    tmo_d = tmo_q;
    if (d_hs || empty)                 tmo_d = '0;
    else if (tmo_q != TMO_W'(TIMEOUT)) tmo_d = tmo_q + TMO_W'(1);
    timeout_d = timeout_q | (tmo_d == TMO_W'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      seq_q     <= '0;
      tmo_q     <= '0;
      pass_q    <= '0;
      err_q     <= '0;
      mism_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unexp_q   <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      seq_q     <= seq_d;
      tmo_q     <= tmo_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      mism_q    <= mism_d;
      ovf_q     <= ovf_d;
      unexp_q   <= unexp_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  end

  assign mismatch = mism_q;
  assign pass_cnt = pass_q;
  assign err_cnt  = err_q;
  assign ovf      = ovf_q;
  assign unexp    = unexp_q;
  assign timeout  = timeout_q;
  assign chk_done = done_q;

`ifdef TL_ROM_CHECK_SVA_EN
  logic [IDX_W-1:0]  sva_idx_q;
  logic [DATA_W-1:0] sva_exp_q, sva_got_q;
  int unsigned       done_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sva_idx_q <= '0;
      sva_exp_q <= '0;
      sva_got_q <= '0;
    end else if (d_hs) begin
      sva_idx_q <= cmp_idx;
      sva_exp_q <= img_q[cmp_idx];
      sva_got_q <= d_data;
    end
  end

  a_no_mismatch: assert property (@(posedge clk) disable iff (!rst_n) !mismatch)
    else $error("tl_rom_resp_checker: compare failed idx=%0d exp=%h got=%h",
                sva_idx_q, sva_exp_q, sva_got_q);

  always @(posedge clk) begin
    if (!rst_n) begin
      done_cycles <= 0;
    end else if (chk_done) begin
      done_cycles <= done_cycles + 1;
      if (done_cycles == 99) $finish;
    end
  end
`else
  // Synthesis build: the counters and flags are the only reporting.
`endif

endmodule
